// File: rtl/sfp_vec_dot_reduce_if.sv
// Valid/ready bundle for the dot-product reduction stage.
// The master side supplies lane vectors and consumes scalar sums. The slave side is the reduction stage.
interface sfp_vec_dot_reduce_if #(
    parameter int N = 3,
    parameter int W = 16
);
    logic           in_valid;
    logic           in_ready;
    logic [N*W-1:0] in_data;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_clip;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_clip
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_clip
    );
endinterface

// File: rtl/sfp_vec_dot_reduce.sv
// Pipelined signed fixed-point lane-sum (dot-product reduction) with a registered adder tree and a narrowing output stage.
// Defining SFP_VEC_DOT_CLIP_CNT_EN adds a 16-bit saturating clip_count output.
module sfp_vec_dot_reduce #(
    parameter int N    = 3,
    parameter int IW   = 8,
    parameter int FW   = 8,
    parameter int CLIP = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    sfp_vec_dot_reduce_if.slave    bus,
    output logic                   clip_sticky,
    input  logic                   clip_clr
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
    ,
    output logic [15:0]            clip_count
`endif
);
    localparam int W  = IW + FW;
    localparam int S  = (N > 1) ? $clog2(N) : 0;
    localparam int P  = 1 << S;
    localparam int WS = W + S;

    localparam logic signed [WS-1:0] SUM_MAX = {{(S+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [WS-1:0] SUM_MIN = {{(S+1){1'b1}}, {(W-1){1'b0}}};
    localparam logic [W-1:0]         SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]         SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic                 adv;
    logic                 in_fire;
    logic                 handoff;
    logic signed [WS-1:0] leaf [0:P-1];
    logic signed [WS-1:0] root_sum;
    logic                 root_vld;
    logic                 sum_hi;
    logic                 sum_lo;
    logic [W-1:0]         sat_data;

    assign adv          = bus.out_ready | ~bus.out_valid;
    assign bus.in_ready = adv;
    assign in_fire      = bus.in_valid & adv;
    assign handoff      = bus.out_valid & bus.out_ready & bus.out_clip;

    // Leaves are sign-extended to full tree width so every level sums exactly; padding leaves are zero
    for (genvar j = 0; j < P; j++) begin : g_leaf
        if (j < N) begin : g_lane
            assign leaf[j] = WS'($signed(bus.in_data[j*W +: W]));
        end else begin : g_pad
            assign leaf[j] = '0;
        end
    end

    if (S == 0) begin : g_passthru
        assign root_sum = leaf[0];
        assign root_vld = in_fire;
    end else begin : g_tree
        // Heap-indexed tree: node i has children 2i+1 and 2i+2, and indices >= P-1 are leaves
        logic signed [WS-1:0] node [0:P-2];
        logic signed [WS-1:0] lhs  [0:P-2];
        logic signed [WS-1:0] rhs  [0:P-2];
        logic [S-1:0]         vld;

        for (genvar i = 0; i < P - 1; i++) begin : g_node
            localparam int LC = 2 * i + 1;
            localparam int RC = 2 * i + 2;
            if (LC >= P - 1) begin : g_from_leaf
                assign lhs[i] = leaf[LC-(P-1)];
                assign rhs[i] = leaf[RC-(P-1)];
            end else begin : g_from_node
                assign lhs[i] = node[LC];
                assign rhs[i] = node[RC];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < P - 1; i++) begin
                    node[i] <= '0;
                end
                vld <= '0;
            end else if (adv) begin
                for (int i = 0; i < P - 1; i++) begin
                    node[i] <= lhs[i] + rhs[i];
                end
                for (int l = S - 1; l > 0; l--) begin
                    vld[l] <= vld[l-1];
                end
                vld[0] <= in_fire;
            end
        end

        assign root_sum = node[0];
        assign root_vld = vld[S-1];
    end

    always_comb begin
        sum_hi   = root_sum > SUM_MAX;
        sum_lo   = root_sum < SUM_MIN;
        sat_data = root_sum[W-1:0];
        if (CLIP != 0) begin
            if (sum_hi) begin
                sat_data = SAT_MAX;
            end else if (sum_lo) begin
                sat_data = SAT_MIN;
            end
        end
    end

    // Output register only loads on a valid sum, so a stalled result stays put
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.out_valid <= 1'b0;
            bus.out_data  <= '0;
            bus.out_clip  <= 1'b0;
        end else if (adv) begin
            bus.out_valid <= root_vld;
            if (root_vld) begin
                bus.out_data <= sat_data;
                bus.out_clip <= sum_hi | sum_lo;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_sticky <= 1'b0;
        end else if (handoff) begin
            clip_sticky <= 1'b1;
        end else if (clip_clr) begin
            clip_sticky <= 1'b0;
        end
    end

`ifdef SFP_VEC_DOT_CLIP_CNT_EN
    // A clear on a clipping handoff still counts that handoff
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clip_count <= '0;
        end else if (clip_clr) begin
            clip_count <= handoff ? 16'd1 : 16'd0;
        end else if (handoff && (clip_count != 16'hFFFF)) begin
            clip_count <= clip_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sfp_vec_dot_reduce.sv
// Directed bench for sfp_vec_dot_reduce: N=3 saturating and wrapping builds, plus N=4 and N=1 builds.
module tb_sfp_vec_dot_reduce;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst;
    logic clr_sat, clr_other;
    logic sticky_sat, sticky_wrap, sticky_n4, sticky_n1;
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
    logic [15:0] count_sat, count_wrap, count_n4, count_n1;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    sfp_vec_dot_reduce_if #(.N(3), .W(W)) bus_sat  ();
    sfp_vec_dot_reduce_if #(.N(3), .W(W)) bus_wrap ();
    sfp_vec_dot_reduce_if #(.N(4), .W(W)) bus_n4   ();
    sfp_vec_dot_reduce_if #(.N(1), .W(W)) bus_n1   ();

    sfp_vec_dot_reduce #(.N(3), .IW(8), .FW(8), .CLIP(1)) dut (
        .clk(clk), .rst(rst), .bus(bus_sat), .clip_sticky(sticky_sat), .clip_clr(clr_sat)
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
        , .clip_count(count_sat)
`endif
    );

    sfp_vec_dot_reduce #(.N(3), .IW(8), .FW(8), .CLIP(0)) dut_wrap (
        .clk(clk), .rst(rst), .bus(bus_wrap), .clip_sticky(sticky_wrap), .clip_clr(clr_other)
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
        , .clip_count(count_wrap)
`endif
    );

    sfp_vec_dot_reduce #(.N(4), .IW(8), .FW(8), .CLIP(1)) dut_n4 (
        .clk(clk), .rst(rst), .bus(bus_n4), .clip_sticky(sticky_n4), .clip_clr(clr_other)
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
        , .clip_count(count_n4)
`endif
    );

    sfp_vec_dot_reduce #(.N(1), .IW(8), .FW(8), .CLIP(1)) dut_n1 (
        .clk(clk), .rst(rst), .bus(bus_n1), .clip_sticky(sticky_n1), .clip_clr(clr_other)
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
        , .clip_count(count_n1)
`endif
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual === expected) begin
            n_pass++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one vector into both N=3 builds; callers keep out_ready=1 so it is accepted on the next edge
    task automatic applyStimulus(input logic [3*W-1:0] vec);
        bus_sat.in_data   = vec;
        bus_wrap.in_data  = vec;
        bus_sat.in_valid  = 1'b1;
        bus_wrap.in_valid = 1'b1;
        tick();
        bus_sat.in_valid  = 1'b0;
        bus_wrap.in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [15:0] got [$];
        int          k;
        int          cyc;
        int          stale;

        rst = 1'b1;
        clr_sat = 1'b0;
        clr_other = 1'b0;
        bus_sat.in_valid = 1'b0;  bus_sat.in_data = '0;  bus_sat.out_ready = 1'b1;
        bus_wrap.in_valid = 1'b0; bus_wrap.in_data = '0; bus_wrap.out_ready = 1'b1;
        bus_n4.in_valid = 1'b0;   bus_n4.in_data = '0;   bus_n4.out_ready = 1'b1;
        bus_n1.in_valid = 1'b0;   bus_n1.in_data = '0;   bus_n1.out_ready = 1'b1;

        #1;
        checkOutput("reset out_valid", 32'(bus_sat.out_valid), 32'd0);
        checkOutput("reset out_data", 32'(bus_sat.out_data), 32'd0);
        checkOutput("reset out_clip", 32'(bus_sat.out_clip), 32'd0);
        checkOutput("reset clip_sticky", 32'(sticky_sat), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("post-reset in_ready", 32'(bus_sat.in_ready), 32'd1);
        tick();

        // 1.5 + 2.25 - 1.0 = 2.75, with a latency of three edges
        applyStimulus({16'hFF00, 16'h0240, 16'h0180});
        tick();
        checkOutput("basic early valid", 32'(bus_sat.out_valid), 32'd0);
        tick();
        checkOutput("basic out_valid", 32'(bus_sat.out_valid), 32'd1);
        checkOutput("basic out_data", 32'(bus_sat.out_data), 32'h02C0);
        checkOutput("basic out_clip", 32'(bus_sat.out_clip), 32'd0);
        checkOutput("basic wrap out_data", 32'(bus_wrap.out_data), 32'h02C0);
        tick();
        checkOutput("basic no duplicate", 32'(bus_sat.out_valid), 32'd0);

        // 300.0 overflows: saturate versus wrap (0x12C00 -> 0x2C00)
        applyStimulus({3{16'h6400}});
        repeat (2) tick();
        checkOutput("pos sat out_data", 32'(bus_sat.out_data), 32'h7FFF);
        checkOutput("pos sat out_clip", 32'(bus_sat.out_clip), 32'd1);
        checkOutput("pos wrap out_data", 32'(bus_wrap.out_data), 32'h2C00);
        checkOutput("pos wrap out_clip", 32'(bus_wrap.out_clip), 32'd1);
        tick();
        checkOutput("pos sat sticky", 32'(sticky_sat), 32'd1);
        checkOutput("pos wrap sticky", 32'(sticky_wrap), 32'd1);

        // -384.0 underflows: saturate to the minimum, and the wrap build keeps 0x8000 as the low bits
        applyStimulus({3{16'h8000}});
        repeat (2) tick();
        checkOutput("neg sat out_data", 32'(bus_sat.out_data), 32'h8000);
        checkOutput("neg sat out_clip", 32'(bus_sat.out_clip), 32'd1);
        checkOutput("neg wrap out_data", 32'(bus_wrap.out_data), 32'h8000);
        tick();
        clr_sat = 1'b1;
        clr_other = 1'b1;
        tick();
        clr_sat = 1'b0;
        clr_other = 1'b0;
        checkOutput("clr sticky sat", 32'(sticky_sat), 32'd0);
        checkOutput("clr sticky wrap", 32'(sticky_wrap), 32'd0);
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
        checkOutput("clr count", 32'(count_sat), 32'd0);
`endif

        bus_n4.in_data = {16'h0400, 16'h0300, 16'h0200, 16'h0100};
        bus_n1.in_data = 16'h1234;
        bus_n4.in_valid = 1'b1;
        bus_n1.in_valid = 1'b1;
        tick();
        bus_n4.in_valid = 1'b0;
        bus_n1.in_valid = 1'b0;
        checkOutput("n1 out_valid", 32'(bus_n1.out_valid), 32'd1);
        checkOutput("n1 out_data", 32'(bus_n1.out_data), 32'h1234);
        checkOutput("n1 out_clip", 32'(bus_n1.out_clip), 32'd0);
        tick();
        checkOutput("n4 early valid", 32'(bus_n4.out_valid), 32'd0);
        tick();
        checkOutput("n4 out_valid", 32'(bus_n4.out_valid), 32'd1);
        checkOutput("n4 out_data", 32'(bus_n4.out_data), 32'h0A00);
        tick();

        // Stream 1..10 while out_ready drops for loop cycles 4..8
        k = 1;
        cyc = 0;
        while (got.size() < 10 && cyc < 60) begin
            bus_sat.out_ready = !(cyc >= 4 && cyc <= 8);
            bus_sat.in_valid  = (k <= 10);
            bus_sat.in_data   = {32'h0, 16'(k)};
            #1;
            if (cyc == 4 || cyc == 8) begin
                checkOutput($sformatf("stall hold c%0d", cyc), 32'(bus_sat.out_data), 32'd2);
                checkOutput($sformatf("stall valid c%0d", cyc), 32'(bus_sat.out_valid), 32'd1);
            end
            if (cyc == 5) checkOutput("stall in_ready", 32'(bus_sat.in_ready), 32'd0);
            if (bus_sat.out_valid && bus_sat.out_ready) got.push_back(bus_sat.out_data);
            if (bus_sat.in_valid && bus_sat.in_ready) k++;
            @(posedge clk);
            #1;
            cyc++;
        end
        bus_sat.in_valid  = 1'b0;
        bus_sat.out_ready = 1'b1;
        checkOutput("stream count", 32'(got.size()), 32'd10);
        for (int i = 0; i < got.size(); i++) begin
            checkOutput($sformatf("stream[%0d]", i), 32'(got[i]), 32'(i + 1));
        end

        // Reset while two beats are in flight
        bus_sat.in_data = {32'h0, 16'h0005};
        bus_sat.in_valid = 1'b1;
        tick();
        bus_sat.in_data = {32'h0, 16'h0006};
        tick();
        bus_sat.in_valid = 1'b0;
        tick();
        checkOutput("pre-reset out_valid", 32'(bus_sat.out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async reset out_valid", 32'(bus_sat.out_valid), 32'd0);
        checkOutput("async reset out_data", 32'(bus_sat.out_data), 32'd0);
        #2;
        rst = 1'b0;
        stale = 0;
        repeat (4) begin
            tick();
            if (bus_sat.out_valid) stale++;
        end
        checkOutput("no stale result", 32'(stale), 32'd0);
        applyStimulus({16'hFF00, 16'h0240, 16'h0180});
        tick();
        tick();
        checkOutput("after reset out_valid", 32'(bus_sat.out_valid), 32'd1);
        checkOutput("after reset out_data", 32'(bus_sat.out_data), 32'h02C0);
        tick();

        repeat (5) applyStimulus({3{16'h6400}});
        repeat (4) tick();
        checkOutput("burst sticky", 32'(sticky_sat), 32'd1);
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
        checkOutput("burst clip_count", 32'(count_sat), 32'd5);
`endif

        // clip_clr on the same edge as a clipping handoff: the set wins
        applyStimulus({3{16'h6400}});
        tick();
        tick();
        checkOutput("set-wins out_valid", 32'(bus_sat.out_valid), 32'd1);
        clr_sat = 1'b1;
        tick();
        clr_sat = 1'b0;
        checkOutput("set-wins sticky", 32'(sticky_sat), 32'd1);
`ifdef SFP_VEC_DOT_CLIP_CNT_EN
        checkOutput("set-wins clip_count", 32'(count_sat), 32'd1);
`endif

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/sfp_vec_dot_reduce.md
Name: sfp_vec_dot_reduce

Overview:
- Pipelined sum-reduction stage directly downstream of the element-wise signed fixed-point vector multiplier.
- Consumes one N-lane vector of products per beat and emits the scalar lane sum, i.e. the dot product, in the same fixed-point format.
- Valid/ready on both sides; full-pipeline stall on back-pressure; per-result clipping flag aligned with the data.
- Feeds the ray/plane intersection and shading datapaths that need scalar dot products.

Parameters:
- N, 3: lane count, >= 1.
- IW, 8: integer bits, sign included.
- FW, 8: fraction bits; element width W = IW+FW.
- CLIP, 1: final narrowing mode; 0 = wrap (two's-complement truncation), 1 = saturate to W-bit min/max.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  stage accepts input this cycle.
- in_data  in  N*W  lane i at bits [i*W +: W], signed QIW.FW.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  W  signed QIW.FW sum.
- out_clip  out  1  out_data was saturated (CLIP=1) or wrapped (CLIP=0).
- clip_sticky  out  1  set by any handed-off out_clip=1 result; cleared by clip_clr.
- clip_clr  in  1  synchronous clear of clip_sticky.

Behaviour:
- Stages: S = ceil(log2 N) registered adder-tree levels plus one output register; latency L = S+1 cycles from input handshake to out_valid. N=1 gives L=1 (pass-through register, out_clip=0).
- Non-power-of-two N: missing tree leaves are zero.
- Width growth: each tree level sign-extends by 1 bit, so the sums are exact internally (W+S bits).
- Narrowing happens only in the output stage:
  - CLIP=1: saturate to [-2^(W-1), 2^(W-1)-1].
  - CLIP=0: keep the low W bits.
  - out_clip = 1 if the exact sum is outside the W-bit range, in either mode.
- Each stage carries a valid bit.
- Global advance enable: adv = out_ready | ~out_valid. When adv=0, all stage registers, valids and out_data hold.
- in_ready = adv, combinational from out_ready. A transfer occurs when in_valid & in_ready.
- Bubbles propagate as valid=0 stages. No combinational path from in_valid/in_data to any output.
- out_data and out_clip are stable while out_valid=1 and out_ready=0.
- Back-pressure: no loss, no duplication, order preserved. Throughput is 1 result/cycle while out_ready=1.
- clip_sticky:
  - Sets on the cycle out_valid & out_ready & out_clip.
  - clip_clr clears it; a set on the same cycle wins.
- Reset (async assert, any time including mid-stream): all valids 0, out_valid=0, out_data=0, out_clip=0, clip_sticky=0. In-flight data is discarded.
- After reset deassert: in_ready=1 on the first edge.

Optional Feature:
- Macro SFP_VEC_DOT_CLIP_CNT_EN.
- Defined: adds output port clip_count, 16 bits.
  - Increments on each handed-off out_clip=1 result and saturates at 0xFFFF.
  - Cleared by clip_clr; an increment on the clear cycle leaves 1.
  - Reset value 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Defaults (N=3, Q8.8): lanes 0x0180, 0x0240, 0xFF00 (1.5, 2.25, -1.0), out_ready=1 -> after 3 cycles out_data=0x02C0 (2.75), out_clip=0.
- CLIP=1: lanes 0x6400 x3 (100.0 each) -> out_data=0x7FFF, out_clip=1, clip_sticky=1. Same stimulus with CLIP=0 -> out_data=0x2C00, out_clip=1.
- Negative saturation, CLIP=1: lanes 0x8000 x3 -> out_data=0x8000, out_clip=1. Then clip_clr pulse -> clip_sticky=0.
- Stream 10 vectors back-to-back with lane0=k (k=1..10), others 0; hold out_ready=0 for cycles 4-8 -> in_ready=0 during the stall. Received sequence is exactly 1..10 with no gaps or duplicates, and out_data is held stable during the stall.
- Assert rst with 2 beats in flight -> out_valid=0 immediately (async). After release, no stale result appears; the next input produces its correct sum at latency 3.
- N=4 and N=1 builds:
  - N=4, lanes 1,2,3,4 (x0x0100) -> 0x0A00 after 3 cycles.
  - N=1, lane 0x1234 -> 0x1234 after 1 cycle.
- With SFP_VEC_DOT_CLIP_CNT_EN: 5 clipping results -> clip_count=5.
